// File: rtl/display_pkg.sv
// Shared definitions for the paged BCD display.
//   disp_state_e : display sequencer states (IDLE, BLANK, PAGE)
//   BLANK_CODE   : digit code that decodes to an unlit display
//   SEG_*        : active-low 7-segment patterns, bit 0 = a ... bit 6 = g
//   num_pages()  : number of pages needed to show all digits
package display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BLANK = 2'd1,
    ST_PAGE  = 2'd2
  } disp_state_e;

  localparam logic [3:0] BLANK_CODE = 4'hF;

  localparam logic [6:0] SEG_OFF = 7'h7F;
  localparam logic [6:0] SEG_0   = 7'h40;
  localparam logic [6:0] SEG_1   = 7'h79;
  localparam logic [6:0] SEG_2   = 7'h24;
  localparam logic [6:0] SEG_3   = 7'h30;
  localparam logic [6:0] SEG_4   = 7'h19;
  localparam logic [6:0] SEG_5   = 7'h12;
  localparam logic [6:0] SEG_6   = 7'h02;
  localparam logic [6:0] SEG_7   = 7'h78;
  localparam logic [6:0] SEG_8   = 7'h00;
  localparam logic [6:0] SEG_9   = 7'h10;

  function automatic int num_pages(input int nd, input int pd);
    return (nd + pd - 1) / pd;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to 7-segment decoder, active-low outputs.
//   code_i : BCD digit code; any code above 9 (including BLANK_CODE) is unlit
//   seg_o  : segments a..g in bits 0..6, 0 = segment lit
module seg7_decode
  import display_pkg::*;
(
  input  logic [3:0] code_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_OFF;
    case (code_i)
      4'd0:    seg_o = SEG_0;
      4'd1:    seg_o = SEG_1;
      4'd2:    seg_o = SEG_2;
      4'd3:    seg_o = SEG_3;
      4'd4:    seg_o = SEG_4;
      4'd5:    seg_o = SEG_5;
      4'd6:    seg_o = SEG_6;
      4'd7:    seg_o = SEG_7;
      4'd8:    seg_o = SEG_8;
      4'd9:    seg_o = SEG_9;
      default: seg_o = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/bcd_page_display.sv
// Shows a wide BCD value on a few 7-segment displays, one page at a time,
// most significant page first, with a blank page between frames. A push
// button starts and stops the sequence. Each frame is taken from a snapshot
// of bcd_in so a frame never mixes two values.
//
// Ports:
//   CLOCK_50    : single clock
//   rst_n       : asynchronous active-low reset (released synchronously)
//   toggle_btn  : active-low push button, asynchronous to CLOCK_50
//   bcd_in      : 4*NUM_DIGITS bits, digit 0 in [3:0]
//   seg_out     : 7*PAGE_DIGITS bits, active-low a..g, display 0 rightmost
//   run         : start/stop state
//   page_idx    : page currently shown, 0 = blank
//   frame_start : one-cycle pulse when a snapshot is taken
//
// Build option: define LEADING_ZERO_BLANK_EN to blank leading zeros
// (digit 0 is always shown).
module bcd_page_display
  import display_pkg::*;
#(
  parameter  int NUM_DIGITS   = 9,
  parameter  int PAGE_DIGITS  = 3,
  parameter  int TICK_DIV     = 25000000,
  parameter  int DEBOUNCE_CYC = 500000,
  localparam int NUM_PAGES    = num_pages(NUM_DIGITS, PAGE_DIGITS),
  localparam int PIW          = $clog2(NUM_PAGES + 1)
) (
  input  logic                     CLOCK_50,
  input  logic                     rst_n,
  input  logic                     toggle_btn,
  input  logic [4*NUM_DIGITS-1:0]  bcd_in,
  output logic [7*PAGE_DIGITS-1:0] seg_out,
  output logic                     run,
  output logic [PIW-1:0]           page_idx,
  output logic                     frame_start
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

  // Reset asserts immediately but is released on a clock edge, so no
  // flop sees a reset release close to its active edge.
  logic [1:0] rst_sync_q;
  logic       rst_int_n;

  always_ff @(posedge CLOCK_50 or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= 2'b00;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end

  assign rst_int_n = rst_sync_q[1];

  logic [1:0]             sync_q;
  logic                   btn_stable_q, btn_stable_d;
  logic [DW-1:0]          db_cnt_q, db_cnt_d;
  logic                   run_q, run_d;
  logic                   btn_press;
  disp_state_e            state_q, state_d;
  logic [PIW-1:0]         page_q, page_d;
  logic [TW-1:0]          tick_cnt_q, tick_cnt_d;
  logic                   tick;
  logic [4*NUM_DIGITS-1:0] snap_q, snap_d;
  logic [7*PAGE_DIGITS-1:0] seg_q, seg_next;
  logic                   frame_start_q, frame_start_d;

  // Debounce: the synchronised level must differ from the accepted level
  // for DEBOUNCE_CYC consecutive cycles before it is accepted. Only an
  // accepted press (1 -> 0) toggles run.
  always_comb begin
    db_cnt_d     = '0;
    btn_stable_d = btn_stable_q;
    btn_press    = 1'b0;
    if (sync_q[1] != btn_stable_q) begin
      if (db_cnt_q == DW'(DEBOUNCE_CYC - 1)) begin
        btn_stable_d = sync_q[1];
        btn_press    = ~sync_q[1];
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
    run_d = run_q ^ btn_press;
  end

  assign tick = (tick_cnt_q == TW'(TICK_DIV - 1));

  // Sequencer. A stop (run low) is tested before the tick so it wins
  // when both happen in the same cycle.
  always_comb begin
    state_d       = state_q;
    page_d        = page_q;
    snap_d        = snap_q;
    frame_start_d = 1'b0;
    tick_cnt_d    = tick ? '0 : tick_cnt_q + 1'b1;
    case (state_q)
      ST_IDLE: begin
        tick_cnt_d = '0;
        page_d     = '0;
        if (run_q) state_d = ST_BLANK;
      end
      ST_BLANK: begin
        if (!run_q) begin
          state_d    = ST_IDLE;
          tick_cnt_d = '0;
        end else if (tick) begin
          state_d       = ST_PAGE;
          page_d        = PIW'(NUM_PAGES);
          snap_d        = bcd_in;
          frame_start_d = 1'b1;
        end
      end
      ST_PAGE: begin
        if (!run_q) begin
          state_d    = ST_IDLE;
          page_d     = '0;
          tick_cnt_d = '0;
        end else if (tick) begin
          if (page_q == PIW'(1)) begin
            state_d = ST_BLANK;
            page_d  = '0;
          end else begin
            page_d = page_q - 1'b1;
          end
        end
      end
      default: begin
        state_d    = ST_IDLE;
        page_d     = '0;
        tick_cnt_d = '0;
      end
    endcase
  end

  // Digit codes for every display slot of every page, taken from the
  // snapshot as it will be after this edge. Slots past the last digit are
  // unlit.
  logic [3:0] shown [NUM_PAGES*PAGE_DIGITS];

`ifdef LEADING_ZERO_BLANK_EN
  // zero_from[k] is set when digits k..NUM_DIGITS-1 are all zero.
  logic [NUM_DIGITS:1] zero_from;
  assign zero_from[NUM_DIGITS] = 1'b1;
  for (genvar gi = 1; gi < NUM_DIGITS; gi++) begin : g_zero
    assign zero_from[gi] = zero_from[gi+1] & (snap_d[4*gi +: 4] == 4'd0);
  end
`endif

  for (genvar gi = 0; gi < NUM_PAGES*PAGE_DIGITS; gi++) begin : g_slot
    if (gi >= NUM_DIGITS) begin : g_pad
      assign shown[gi] = BLANK_CODE;
    end else if (gi == 0) begin : g_lsd
      assign shown[gi] = snap_d[3:0];
    end else begin : g_dig
`ifdef LEADING_ZERO_BLANK_EN
      assign shown[gi] = zero_from[gi] ? BLANK_CODE : snap_d[4*gi +: 4];
`else
      assign shown[gi] = snap_d[4*gi +: 4];
`endif
    end
  end

  // One decoder per physical display; page 0 (idle/blank) selects nothing.
  for (genvar gi = 0; gi < PAGE_DIGITS; gi++) begin : g_pos
    logic [3:0] code;
    always_comb begin
      code = BLANK_CODE;
      for (int p = 1; p <= NUM_PAGES; p++) begin
        if (page_d == PIW'(p)) code = shown[(p-1)*PAGE_DIGITS + gi];
      end
    end
    seg7_decode u_dec (
      .code_i (code),
      .seg_o  (seg_next[7*gi +: 7])
    );
  end

  always_ff @(posedge CLOCK_50 or negedge rst_int_n) begin
    if (!rst_int_n) begin
      sync_q        <= 2'b11;
      btn_stable_q  <= 1'b1;
      db_cnt_q      <= '0;
      run_q         <= 1'b0;
      state_q       <= ST_IDLE;
      page_q        <= '0;
      tick_cnt_q    <= '0;
      snap_q        <= '0;
      seg_q         <= '1;
      frame_start_q <= 1'b0;
    end else begin
      sync_q        <= {sync_q[0], toggle_btn};
      btn_stable_q  <= btn_stable_d;
      db_cnt_q      <= db_cnt_d;
      run_q         <= run_d;
      state_q       <= state_d;
      page_q        <= page_d;
      tick_cnt_q    <= tick_cnt_d;
      snap_q        <= snap_d;
      seg_q         <= seg_next;
      frame_start_q <= frame_start_d;
    end
  end

  assign seg_out     = seg_q;
  assign run         = run_q;
  assign page_idx    = page_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_bcd_page_display.sv
module tb_bcd_page_display;

  localparam int TICK = 4;
  localparam int DEB  = 8;
  localparam int NP   = 3;

  localparam logic [6:0] SEG_TAB [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  logic        clk = 1'b0;
  logic        rst_n;
  logic        btn9, btn7;
  logic [35:0] bcd9;
  logic [27:0] bcd7;
  logic [20:0] seg9, seg7;
  logic        run9, run7, fs9, fs7;
  logic [1:0]  pg9, pg7;

  bit          sel7;
  logic [20:0] seg_s;
  logic        run_s, fs_s;
  logic [1:0]  pg_s;

  int          checks, errors;
  int unsigned cyc = 0;
  int unsigned last_fs_cyc;
  logic [35:0] cur9;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bcd_page_display #(.NUM_DIGITS(9), .PAGE_DIGITS(3), .TICK_DIV(TICK), .DEBOUNCE_CYC(DEB)) dut (
    .CLOCK_50(clk), .rst_n(rst_n), .toggle_btn(btn9), .bcd_in(bcd9),
    .seg_out(seg9), .run(run9), .page_idx(pg9), .frame_start(fs9));

  bcd_page_display #(.NUM_DIGITS(7), .PAGE_DIGITS(3), .TICK_DIV(TICK), .DEBOUNCE_CYC(DEB)) dut7 (
    .CLOCK_50(clk), .rst_n(rst_n), .toggle_btn(btn7), .bcd_in(bcd7),
    .seg_out(seg7), .run(run7), .page_idx(pg7), .frame_start(fs7));

  assign seg_s = sel7 ? seg7 : seg9;
  assign run_s = sel7 ? run7 : run9;
  assign fs_s  = sel7 ? fs7  : fs9;
  assign pg_s  = sel7 ? pg7  : pg9;

  // Expected display for a page: page p shows digits (p-1)*3 .. p*3-1,
  // display 0 rightmost; absent digits, codes > 9 (and, with the option,
  // leading zeros above digit 0) are unlit.
  function automatic logic [20:0] exp_seg(input logic [35:0] v, input int nd, input int page);
    logic [20:0] r;
    logic [3:0]  d;
    int          k;
    bit          blank;
    r = '1;
    if (page == 0) return r;
    for (int i = 0; i < 3; i++) begin
      k = (page - 1) * 3 + i;
      if (k < nd) begin
        d = v[4*k +: 4];
        blank = (d > 4'd9);
`ifdef LEADING_ZERO_BLANK_EN
        if (k > 0 && (v >> (4*k)) == 36'd0) blank = 1'b1;
`endif
        if (!blank) r[7*i +: 7] = SEG_TAB[d];
      end
    end
    return r;
  endfunction

  function automatic logic [35:0] rand_bcd(input int nd);
    logic [35:0] v;
    int          top;
    v   = '0;
    top = $urandom_range(1, nd);
    for (int k = 0; k < top; k++) v[4*k +: 4] = 4'($urandom_range(0, 11));
    return v;
  endfunction

  task automatic set_bcd(input logic [35:0] v);
    if (sel7) bcd7 = v[27:0];
    else      bcd9 = v;
  endtask

  task automatic set_btn(input logic lvl);
    if (sel7) btn7 = lvl;
    else      btn9 = lvl;
  endtask

  // Press and hold until run rises, then measure run-rise to frame_start.
  task automatic start_run(input string tag);
    int n;
    set_btn(1'b0);
    n = 0;
    while (!run_s && n < 4*DEB) begin @(negedge clk); n++; end
    checks++;
    if (run_s !== 1'b1) begin
      errors++;
      $display("FAIL %s run_rise: got run=%b, expected 1 within %0d cycles", tag, run_s, 4*DEB);
      set_btn(1'b1);
      return;
    end
    n = 0;
    while (!fs_s && n < 50) begin @(negedge clk); n++; end
    checks++;
    if (n != TICK + 1) begin
      errors++;
      $display("FAIL %s start_latency: got %0d cycles, expected %0d", tag, n, TICK + 1);
    end
    set_btn(1'b1);
    $display("start %s: run high, first frame after %0d cycles", tag, n);
  endtask

  // Check one full frame showing snapshot cur; nxt is driven onto bcd_in
  // while page 3 is up and must not appear before the next frame.
  task automatic check_frame(input logic [35:0] cur, input logic [35:0] nxt,
                             input bit chained, input string tag);
    int n, nd;
    nd = sel7 ? 7 : 9;
    n  = 0;
    while (!fs_s && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (fs_s !== 1'b1) begin
      errors++;
      $display("FAIL %s frame_start: got none, expected a pulse within 200 cycles", tag);
      return;
    end
    if (chained) begin
      checks++;
      if (cyc - last_fs_cyc != (NP + 1) * TICK) begin
        errors++;
        $display("FAIL %s frame_period: got %0d, expected %0d", tag, cyc - last_fs_cyc, (NP + 1) * TICK);
      end
    end
    last_fs_cyc = cyc;
    checks++;
    if (pg_s !== 2'd3) begin
      errors++;
      $display("FAIL %s page3_idx: got %0d, expected 3", tag, pg_s);
    end
    checks++;
    if (seg_s !== exp_seg(cur, nd, 3)) begin
      errors++;
      $display("FAIL %s page3_seg: got %h, expected %h", tag, seg_s, exp_seg(cur, nd, 3));
    end
    set_bcd(nxt);
    @(negedge clk);
    checks++;
    if (fs_s !== 1'b0) begin
      errors++;
      $display("FAIL %s pulse_width: got frame_start=%b, expected 0", tag, fs_s);
    end
    for (int p = 2; p >= 0; p--) begin
      repeat ((p == 2) ? TICK - 1 : TICK) @(negedge clk);
      checks++;
      if (pg_s !== 2'(p)) begin
        errors++;
        $display("FAIL %s page%0d_idx: got %0d, expected %0d", tag, p, pg_s, p);
      end
      checks++;
      if (seg_s !== exp_seg(cur, nd, p)) begin
        errors++;
        $display("FAIL %s page%0d_seg: got %h, expected %h", tag, p, seg_s, exp_seg(cur, nd, p));
      end
    end
    $display("frame %s: snapshot %h, next input %h", tag, cur, nxt);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (seg9 !== '1)   begin errors++; $display("FAIL reset_seg9: got %h, expected 1fffff", seg9); end
    checks++; if (run9 !== 1'b0) begin errors++; $display("FAIL reset_run9: got %b, expected 0", run9); end
    checks++; if (pg9 !== 2'd0)  begin errors++; $display("FAIL reset_pg9: got %0d, expected 0", pg9); end
    checks++; if (fs9 !== 1'b0)  begin errors++; $display("FAIL reset_fs9: got %b, expected 0", fs9); end
    checks++; if (seg7 !== '1)   begin errors++; $display("FAIL reset_seg7: got %h, expected 1fffff", seg7); end
    checks++; if (run7 !== 1'b0) begin errors++; $display("FAIL reset_run7: got %b, expected 0", run7); end
    rst_n = 1'b1;
    $display("reset: outputs idle");
  endtask

  task automatic test_bounce();
    bit bad;
    int len;
    sel7 = 0;
    bad  = 0;
    for (int i = 0; i < 6; i++) begin
      len = $urandom_range(1, DEB - 1);
      btn9 = 1'b0;
      repeat (len) @(negedge clk);
      btn9 = 1'b1;
      repeat ($urandom_range(1, 4)) @(negedge clk);
      $display("bounce %0d: low for %0d cycles", i, len);
    end
    for (int i = 0; i < DEB + 8; i++) begin
      @(negedge clk);
      if (run9 !== 1'b0 || seg9 !== '1 || fs9 !== 1'b0) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL bounce_run: got run=%b seg=%h, expected run=0 seg=1fffff", run9, seg9);
    end
  endtask

  task automatic test_frames();
    logic [35:0] nxt;
    sel7 = 0;
    cur9 = 36'h123456789;
    set_bcd(cur9);
    start_run("main");
    check_frame(cur9, cur9, 0, "fixed_a");
    check_frame(cur9, 36'h987654321, 1, "fixed_b");
    cur9 = 36'h987654321;
    check_frame(cur9, 36'h000000042, 1, "changed");
    cur9 = 36'h000000042;
    check_frame(cur9, 36'h0000000A0, 1, "small");
    cur9 = 36'h0000000A0;
    for (int i = 0; i < 6; i++) begin
      nxt = rand_bcd(9);
      check_frame(cur9, nxt, 1, $sformatf("rand%0d", i));
      cur9 = nxt;
    end
  endtask

  // Second press timed so run falls in the tick cycle ending page 2.
  task automatic test_stop_on_tick();
    int  n, stop_at;
    bit  saw_fs;
    sel7 = 0;
    n = 0;
    while (!fs9 && n < 200) begin @(negedge clk); n++; end
    checks++;
    if (fs9 !== 1'b1) begin
      errors++;
      $display("FAIL stop_sync: got no frame_start, expected one within 200 cycles");
      return;
    end
    // run changes DEB+2 edges after the button goes low; aim it at the
    // edge that starts the last cycle of page 2 in the following frame.
    repeat ((NP + 3) * TICK - 3 - DEB) @(negedge clk);
    btn9    = 1'b0;
    stop_at = -1;
    saw_fs  = 0;
    for (int i = 0; i < DEB + 40; i++) begin
      @(negedge clk);
      if (i == DEB + 6) btn9 = 1'b1;
      if (stop_at >= 0 && fs9) saw_fs = 1;
      if (stop_at < 0 && !run9) begin
        stop_at = i;
        checks++;
        if (pg9 !== 2'd2) begin
          errors++;
          $display("FAIL stop_page: got page %0d when run fell, expected 2", pg9);
        end
      end else if (stop_at >= 0 && i == stop_at + 1) begin
        checks++;
        if (pg9 !== 2'd0) begin errors++; $display("FAIL stop_idx: got %0d, expected 0", pg9); end
        checks++;
        if (seg9 !== '1) begin errors++; $display("FAIL stop_seg: got %h, expected 1fffff", seg9); end
      end
    end
    checks++;
    if (stop_at < 0) begin errors++; $display("FAIL stop_run: got run=%b, expected 0", run9); end
    checks++;
    if (saw_fs) begin errors++; $display("FAIL stop_frame: got frame_start after stop, expected none"); end
    checks++;
    if (seg9 !== '1 || pg9 !== 2'd0) begin
      errors++;
      $display("FAIL stop_idle: got seg=%h page=%0d, expected 1fffff/0", seg9, pg9);
    end
    $display("stop: run fell at step %0d", stop_at);
  endtask

  task automatic test_restart();
    sel7 = 0;
    start_run("restart");
    check_frame(cur9, cur9, 0, "restart_a");
    check_frame(cur9, cur9, 1, "restart_b");
  endtask

  task automatic test_reset_midframe();
    int n;
    bit bad;
    sel7 = 0;
    n = 0;
    while (!fs9 && n < 200) begin @(negedge clk); n++; end
    repeat (TICK + 1) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++; if (seg9 !== '1)   begin errors++; $display("FAIL mid_reset_seg: got %h, expected 1fffff", seg9); end
    checks++; if (run9 !== 1'b0) begin errors++; $display("FAIL mid_reset_run: got %b, expected 0", run9); end
    checks++; if (pg9 !== 2'd0)  begin errors++; $display("FAIL mid_reset_pg: got %0d, expected 0", pg9); end
    checks++; if (fs9 !== 1'b0)  begin errors++; $display("FAIL mid_reset_fs: got %b, expected 0", fs9); end
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 3 * (NP + 1) * TICK; i++) begin
      @(negedge clk);
      if (fs9 !== 1'b0 || run9 !== 1'b0 || seg9 !== '1) bad = 1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL mid_reset_resume: got run=%b seg=%h, expected idle after reset", run9, seg9);
    end
    $display("mid-frame reset: outputs idle");
  endtask

  task automatic test_short_digits();
    logic [35:0] a, b;
    sel7 = 1;
    a = 36'h001234567;
    b = rand_bcd(7);
    set_bcd(a);
    start_run("short");
    check_frame(a, b, 0, "short_a");
    check_frame(b, b, 1, "short_b");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    sel7   = 0;
    rst_n  = 1'b0;
    btn9   = 1'b1;
    btn7   = 1'b1;
    bcd9   = '0;
    bcd7   = '0;
    last_fs_cyc = 0;
    test_reset();
    test_bounce();
    test_frames();
    test_stop_on_tick();
    test_restart();
    test_reset_midframe();
    test_short_digits();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got no completion, expected finish before time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
